// File: rtl/imuldiv_muldiv_dispatch_pkg.sv
// Shared encodings for the mul/div dispatch front end: the muldiv request
// function codes, the dispatch FSM states and small fn decode helpers.
package imuldiv_muldiv_dispatch_pkg;

    localparam logic [2:0] FN_MUL  = 3'd0;
    localparam logic [2:0] FN_DIV  = 3'd1;
    localparam logic [2:0] FN_DIVU = 3'd2;
    localparam logic [2:0] FN_REM  = 3'd3;
    localparam logic [2:0] FN_REMU = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Codes 5..7 have no unit behind them.
    function automatic logic fn_legal(input logic [2:0] fn);
        return fn <= FN_REMU;
    endfunction

    // The divider takes a single signed/unsigned select bit.
    function automatic logic fn_signed(input logic [2:0] fn);
        return (fn == FN_DIV) || (fn == FN_REM);
    endfunction

endpackage

// File: rtl/imuldiv_muldiv_resp_buf.sv
// One-entry result register for the dispatch unit. Loaded once per operation,
// then presented on a val/rdy output until the consumer takes it.
module imuldiv_muldiv_resp_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld,
    input  logic [W-1:0] ld_data,
    output logic         out_val,
    input  logic         out_rdy,
    output logic [W-1:0] out_data
);

    logic         full;
    logic [W-1:0] data;

    // Fill on load, drain on output fire; data is held while waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            data <= '0;
        end else if (ld) begin
            full <= 1'b1;
            data <= ld_data;
        end else if (full && out_rdy) begin
            full <= 1'b0;
        end
    end

    assign out_val  = full;
    assign out_data = data;

endmodule

// File: rtl/imuldiv_muldiv_dispatch.sv
// Front end of the iterative mul/div unit: accepts one request, issues it to
// the multiplier or divider, captures the 64-bit result and returns it.
// Optional feature: IMULDIV_DIVZERO_BYPASS_EN answers divide-by-zero
// requests locally with {a, all-ones} instead of dispatching them.
module imuldiv_muldiv_dispatch
    import imuldiv_muldiv_dispatch_pkg::*;
#(
    parameter int DW   = 32,
    parameter int FN_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [FN_W-1:0] muldivreq_msg_fn,
    input  logic [DW-1:0]   muldivreq_msg_a,
    input  logic [DW-1:0]   muldivreq_msg_b,
    input  logic            muldivreq_val,
    output logic            muldivreq_rdy,
    output logic [2*DW-1:0] muldivresp_msg_result,
    output logic            muldivresp_val,
    input  logic            muldivresp_rdy,
    output logic [DW-1:0]   mulreq_msg_a,
    output logic [DW-1:0]   mulreq_msg_b,
    output logic            mulreq_val,
    input  logic            mulreq_rdy,
    input  logic [2*DW-1:0] mulresp_msg_result,
    input  logic            mulresp_val,
    output logic            mulresp_rdy,
    output logic            divreq_msg_fn,
    output logic [DW-1:0]   divreq_msg_a,
    output logic [DW-1:0]   divreq_msg_b,
    output logic            divreq_val,
    input  logic            divreq_rdy,
    input  logic [2*DW-1:0] divresp_msg_result,
    input  logic            divresp_val,
    output logic            divresp_rdy
);

    state_t            state, state_n;
    logic [FN_W-1:0]   fn_q;
    logic [DW-1:0]     a_q, b_q;
    logic              latch;
    logic              buf_ld;
    logic [2*DW-1:0]   buf_din;
    logic              is_mul;

    assign is_mul        = (fn_q == FN_MUL);
    assign mulreq_msg_a  = a_q;
    assign mulreq_msg_b  = b_q;
    assign divreq_msg_a  = a_q;
    assign divreq_msg_b  = b_q;
    assign divreq_msg_fn = fn_signed(fn_q);

    // State and latched request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            fn_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_n;
            if (latch) begin
                fn_q <= muldivreq_msg_fn;
                a_q  <= muldivreq_msg_a;
                b_q  <= muldivreq_msg_b;
            end
        end
    end

    // Next state and handshakes; only the selected unit ever sees val or rdy.
    always_comb begin
        state_n       = state;
        muldivreq_rdy = 1'b0;
        mulreq_val    = 1'b0;
        divreq_val    = 1'b0;
        mulresp_rdy   = 1'b0;
        divresp_rdy   = 1'b0;
        latch         = 1'b0;
        buf_ld        = 1'b0;
        buf_din       = '0;
        case (state)
            ST_IDLE: begin
                muldivreq_rdy = 1'b1;
                if (muldivreq_val) begin
                    latch = 1'b1;
                    if (!fn_legal(muldivreq_msg_fn)) begin
                        state_n = ST_RESP;
                        buf_ld  = 1'b1;
                    end
`ifdef IMULDIV_DIVZERO_BYPASS_EN
                    else if (muldivreq_msg_fn != FN_MUL && muldivreq_msg_b == '0) begin
                        state_n = ST_RESP;
                        buf_ld  = 1'b1;
                        buf_din = {muldivreq_msg_a, {DW{1'b1}}};
                    end
`endif
                    else begin
                        state_n = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                mulreq_val = is_mul;
                divreq_val = !is_mul;
                if (is_mul ? mulreq_rdy : divreq_rdy)
                    state_n = ST_WAIT;
            end
            ST_WAIT: begin
                mulresp_rdy = is_mul;
                divresp_rdy = !is_mul;
                if (is_mul ? mulresp_val : divresp_val) begin
                    state_n = ST_RESP;
                    buf_ld  = 1'b1;
                    buf_din = is_mul ? mulresp_msg_result : divresp_msg_result;
                end
            end
            ST_RESP: begin
                if (muldivresp_val && muldivresp_rdy)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    imuldiv_muldiv_resp_buf #(.W(2*DW)) u_resp_buf (
        .clk      (clk),
        .reset    (reset),
        .ld       (buf_ld),
        .ld_data  (buf_din),
        .out_val  (muldivresp_val),
        .out_rdy  (muldivresp_rdy),
        .out_data (muldivresp_msg_result)
    );

endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
// Directed bench for the mul/div dispatch front end. The bench plays both the
// pipeline and the two iterative units; inputs change and outputs are checked
// on the falling edge.
module tb_imuldiv_muldiv_dispatch;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  muldivreq_msg_fn;
    logic [31:0] muldivreq_msg_a, muldivreq_msg_b;
    logic        muldivreq_val, muldivreq_rdy;
    logic [63:0] muldivresp_msg_result;
    logic        muldivresp_val, muldivresp_rdy;
    logic [31:0] mulreq_msg_a, mulreq_msg_b;
    logic        mulreq_val, mulreq_rdy;
    logic [63:0] mulresp_msg_result;
    logic        mulresp_val, mulresp_rdy;
    logic        divreq_msg_fn;
    logic [31:0] divreq_msg_a, divreq_msg_b;
    logic        divreq_val, divreq_rdy;
    logic [63:0] divresp_msg_result;
    logic        divresp_val, divresp_rdy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imuldiv_muldiv_dispatch dut (
        .clk                   (clk),
        .reset                 (reset),
        .muldivreq_msg_fn      (muldivreq_msg_fn),
        .muldivreq_msg_a       (muldivreq_msg_a),
        .muldivreq_msg_b       (muldivreq_msg_b),
        .muldivreq_val         (muldivreq_val),
        .muldivreq_rdy         (muldivreq_rdy),
        .muldivresp_msg_result (muldivresp_msg_result),
        .muldivresp_val        (muldivresp_val),
        .muldivresp_rdy        (muldivresp_rdy),
        .mulreq_msg_a          (mulreq_msg_a),
        .mulreq_msg_b          (mulreq_msg_b),
        .mulreq_val            (mulreq_val),
        .mulreq_rdy            (mulreq_rdy),
        .mulresp_msg_result    (mulresp_msg_result),
        .mulresp_val           (mulresp_val),
        .mulresp_rdy           (mulresp_rdy),
        .divreq_msg_fn         (divreq_msg_fn),
        .divreq_msg_a          (divreq_msg_a),
        .divreq_msg_b          (divreq_msg_b),
        .divreq_val            (divreq_val),
        .divreq_rdy            (divreq_rdy),
        .divresp_msg_result    (divresp_msg_result),
        .divresp_val           (divresp_val),
        .divresp_rdy           (divresp_rdy)
    );

    task automatic step;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        n_checks++; if (muldivreq_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_req_rdy: got %b want 1", muldivreq_rdy); end
        n_checks++; if (muldivresp_val !== 1'b0) begin n_fail++; $display("FAIL reset_resp_val: got %b want 0", muldivresp_val); end
        n_checks++; if ({mulreq_val, divreq_val, mulresp_rdy, divresp_rdy} !== 4'b0) begin n_fail++; $display("FAIL reset_unit_hs: got %b want 0000", {mulreq_val, divreq_val, mulresp_rdy, divresp_rdy}); end
        n_checks++; if (muldivresp_msg_result !== 64'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", muldivresp_msg_result); end
        n_checks++; if ({mulreq_msg_a, divreq_msg_b} !== 64'h0) begin n_fail++; $display("FAIL reset_operands: got %h want 0", {mulreq_msg_a, divreq_msg_b}); end
    endtask

    // MUL 7 * -3; an unrelated divider response is offered and must be ignored.
    task automatic test_mul;
        muldivreq_msg_fn = 3'd0; muldivreq_msg_a = 32'd7; muldivreq_msg_b = 32'hFFFF_FFFD;
        muldivreq_val = 1'b1; mulreq_rdy = 1'b1;
        step();
        muldivreq_val = 1'b0;
        n_checks++; if ({mulreq_val, divreq_val} !== 2'b10) begin n_fail++; $display("FAIL mul_issue_val: got %b want 10", {mulreq_val, divreq_val}); end
        n_checks++; if ({mulreq_msg_a, mulreq_msg_b} !== {32'd7, 32'hFFFF_FFFD}) begin n_fail++; $display("FAIL mul_operands: got %h want %h", {mulreq_msg_a, mulreq_msg_b}, {32'd7, 32'hFFFF_FFFD}); end
        n_checks++; if (muldivreq_rdy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_rdy: got %b want 0", muldivreq_rdy); end
        step();
        mulreq_rdy = 1'b0;
        n_checks++; if ({mulresp_rdy, divresp_rdy, mulreq_val} !== 3'b100) begin n_fail++; $display("FAIL mul_wait_hs: got %b want 100", {mulresp_rdy, divresp_rdy, mulreq_val}); end
        mulresp_msg_result = 64'hFFFF_FFFF_FFFF_FFEB; mulresp_val = 1'b1;
        divresp_msg_result = 64'hDEAD_BEEF_0BAD_F00D; divresp_val = 1'b1;
        step();
        mulresp_val = 1'b0; divresp_val = 1'b0;
        n_checks++; if (muldivresp_val !== 1'b1) begin n_fail++; $display("FAIL mul_resp_val: got %b want 1", muldivresp_val); end
        n_checks++; if (muldivresp_msg_result !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL mul_result: got %h want ffffffffffffffeb", muldivresp_msg_result); end
        muldivresp_rdy = 1'b1;
        step();
        muldivresp_rdy = 1'b0;
        n_checks++; if ({muldivresp_val, muldivreq_rdy} !== 2'b01) begin n_fail++; $display("FAIL mul_done: got %b want 01", {muldivresp_val, muldivreq_rdy}); end
    endtask

    // DIV -20 / 3; an unrelated multiplier response must be ignored.
    task automatic test_div;
        muldivreq_msg_fn = 3'd1; muldivreq_msg_a = 32'hFFFF_FFEC; muldivreq_msg_b = 32'd3;
        muldivreq_val = 1'b1; divreq_rdy = 1'b1;
        step();
        muldivreq_val = 1'b0;
        n_checks++; if ({mulreq_val, divreq_val, divreq_msg_fn} !== 3'b011) begin n_fail++; $display("FAIL div_issue: got %b want 011", {mulreq_val, divreq_val, divreq_msg_fn}); end
        n_checks++; if ({divreq_msg_a, divreq_msg_b} !== {32'hFFFF_FFEC, 32'd3}) begin n_fail++; $display("FAIL div_operands: got %h want %h", {divreq_msg_a, divreq_msg_b}, {32'hFFFF_FFEC, 32'd3}); end
        step();
        divreq_rdy = 1'b0;
        n_checks++; if ({mulresp_rdy, divresp_rdy} !== 2'b01) begin n_fail++; $display("FAIL div_wait_rdy: got %b want 01", {mulresp_rdy, divresp_rdy}); end
        divresp_msg_result = {32'hFFFF_FFFE, 32'hFFFF_FFFA}; divresp_val = 1'b1;
        mulresp_msg_result = 64'h1111_2222_3333_4444; mulresp_val = 1'b1;
        step();
        divresp_val = 1'b0; mulresp_val = 1'b0;
        n_checks++; if (muldivresp_msg_result !== 64'hFFFF_FFFE_FFFF_FFFA || muldivresp_val !== 1'b1) begin n_fail++; $display("FAIL div_result: got %b/%h want 1/fffffffefffffffa", muldivresp_val, muldivresp_msg_result); end
        muldivresp_rdy = 1'b1;
        step();
        muldivresp_rdy = 1'b0;
    endtask

    // REMU 20 % 6 with a slow divider and a stalled consumer; a competing
    // request is held valid the whole time and must not be taken.
    task automatic test_stall;
        muldivreq_msg_fn = 3'd4; muldivreq_msg_a = 32'd20; muldivreq_msg_b = 32'd6;
        muldivreq_val = 1'b1; divreq_rdy = 1'b1;
        step();
        muldivreq_msg_fn = 3'd0; muldivreq_msg_a = 32'd99; muldivreq_msg_b = 32'd98;
        n_checks++; if (divreq_msg_fn !== 1'b0) begin n_fail++; $display("FAIL remu_fn: got %b want 0", divreq_msg_fn); end
        step();
        divreq_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if ({divresp_rdy, muldivresp_val, muldivreq_rdy} !== 3'b100) begin n_fail++; $display("FAIL remu_wait_%0d: got %b want 100", i, {divresp_rdy, muldivresp_val, muldivreq_rdy}); end
            step();
        end
        divresp_msg_result = {32'd2, 32'd3}; divresp_val = 1'b1;
        step();
        divresp_val = 1'b0; divresp_msg_result = 64'h0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if ({muldivresp_val, muldivreq_rdy} !== 2'b10 || muldivresp_msg_result !== {32'd2, 32'd3}) begin n_fail++; $display("FAIL remu_hold_%0d: got %b/%h want 10/%h", i, {muldivresp_val, muldivreq_rdy}, muldivresp_msg_result, {32'd2, 32'd3}); end
            step();
        end
        muldivresp_rdy = 1'b1;
        step();
        muldivresp_rdy = 1'b0; muldivreq_val = 1'b0;
        n_checks++; if ({muldivresp_val, muldivreq_rdy, divreq_val, mulreq_val} !== 4'b0100) begin n_fail++; $display("FAIL remu_done: got %b want 0100", {muldivresp_val, muldivreq_rdy, divreq_val, mulreq_val}); end
    endtask

    // Illegal fn: answered locally with zero in the cycle after accept.
    task automatic test_illegal;
        muldivreq_msg_fn = 3'd6; muldivreq_msg_a = 32'd5; muldivreq_msg_b = 32'd7;
        muldivreq_val = 1'b1; mulreq_rdy = 1'b1; divreq_rdy = 1'b1;
        step();
        muldivreq_val = 1'b0;
        n_checks++; if ({muldivresp_val, mulreq_val, divreq_val} !== 3'b100) begin n_fail++; $display("FAIL illegal_hs: got %b want 100", {muldivresp_val, mulreq_val, divreq_val}); end
        n_checks++; if (muldivresp_msg_result !== 64'h0) begin n_fail++; $display("FAIL illegal_result: got %h want 0", muldivresp_msg_result); end
        muldivresp_rdy = 1'b1;
        step();
        muldivresp_rdy = 1'b0; mulreq_rdy = 1'b0; divreq_rdy = 1'b0;
        n_checks++; if ({muldivresp_val, muldivreq_rdy} !== 2'b01) begin n_fail++; $display("FAIL illegal_done: got %b want 01", {muldivresp_val, muldivreq_rdy}); end
    endtask

    // DIV by zero: bypassed locally when the feature is built in, else dispatched.
    task automatic test_divzero;
        muldivreq_msg_fn = 3'd1; muldivreq_msg_a = 32'h1234_5678; muldivreq_msg_b = 32'h0;
        muldivreq_val = 1'b1; divreq_rdy = 1'b0;
        step();
        muldivreq_val = 1'b0;
`ifdef IMULDIV_DIVZERO_BYPASS_EN
        n_checks++; if ({muldivresp_val, divreq_val} !== 2'b10) begin n_fail++; $display("FAIL divzero_bypass_hs: got %b want 10", {muldivresp_val, divreq_val}); end
        n_checks++; if (muldivresp_msg_result !== 64'h1234_5678_FFFF_FFFF) begin n_fail++; $display("FAIL divzero_bypass_result: got %h want 12345678ffffffff", muldivresp_msg_result); end
`else
        n_checks++; if ({muldivresp_val, divreq_val} !== 2'b01) begin n_fail++; $display("FAIL divzero_dispatch_hs: got %b want 01", {muldivresp_val, divreq_val}); end
        divreq_rdy = 1'b1;
        step();
        divreq_rdy = 1'b0;
        divresp_msg_result = 64'h1234_5678_FFFF_FFFF; divresp_val = 1'b1;
        step();
        divresp_val = 1'b0;
        n_checks++; if (muldivresp_msg_result !== 64'h1234_5678_FFFF_FFFF || muldivresp_val !== 1'b1) begin n_fail++; $display("FAIL divzero_dispatch_result: got %b/%h want 1/12345678ffffffff", muldivresp_val, muldivresp_msg_result); end
`endif
        muldivresp_rdy = 1'b1;
        step();
        muldivresp_rdy = 1'b0;
    endtask

    // Reset while waiting on the divider; the response arriving alongside is dropped.
    task automatic test_reset_in_wait;
        muldivreq_msg_fn = 3'd2; muldivreq_msg_a = 32'd9; muldivreq_msg_b = 32'd2;
        muldivreq_val = 1'b1; divreq_rdy = 1'b1;
        step();
        muldivreq_val = 1'b0;
        step();
        divreq_rdy = 1'b0;
        n_checks++; if (divresp_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_wait_reached: got %b want 1", divresp_rdy); end
        reset = 1'b1;
        divresp_msg_result = 64'h0000_0001_0000_0004; divresp_val = 1'b1;
        step();
        reset = 1'b0;
        n_checks++; if ({muldivresp_val, mulreq_val, divreq_val, divresp_rdy, muldivreq_rdy} !== 5'b00001) begin n_fail++; $display("FAIL rst_wait_idle: got %b want 00001", {muldivresp_val, mulreq_val, divreq_val, divresp_rdy, muldivreq_rdy}); end
        step();
        divresp_val = 1'b0;
        n_checks++; if (muldivresp_val !== 1'b0 || muldivresp_msg_result !== 64'h0) begin n_fail++; $display("FAIL rst_late_resp: got %b/%h want 0/0", muldivresp_val, muldivresp_msg_result); end
    endtask

    initial begin
        reset = 1'b1;
        muldivreq_msg_fn = 3'd0; muldivreq_msg_a = 32'h0; muldivreq_msg_b = 32'h0;
        muldivreq_val = 1'b0; muldivresp_rdy = 1'b0;
        mulreq_rdy = 1'b0; mulresp_val = 1'b0; mulresp_msg_result = 64'h0;
        divreq_rdy = 1'b0; divresp_val = 1'b0; divresp_msg_result = 64'h0;
        step();
        test_reset();
        test_mul();
        test_div();
        test_stall();
        test_illegal();
        test_divzero();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
